// File: rtl/timer_regs_pkg.sv
// Shared definitions for the high-resolution timer host: slave register map,
// control/status bit positions, command opcodes and the host FSM states.
package timer_regs_pkg;

  // Word addresses on the timer s1 port
  localparam logic [2:0] ADDR_STATUS   = 3'd0;
  localparam logic [2:0] ADDR_CONTROL  = 3'd1;
  localparam logic [2:0] ADDR_PERIOD_L = 3'd2;
  localparam logic [2:0] ADDR_PERIOD_H = 3'd3;
  localparam logic [2:0] ADDR_SNAP_L   = 3'd4;
  localparam logic [2:0] ADDR_SNAP_H   = 3'd5;

  // Control register bits
  localparam int CTL_ITO   = 0;
  localparam int CTL_CONT  = 1;
  localparam int CTL_START = 2;
  localparam int CTL_STOP  = 3;

  // Status register bits
  localparam int ST_TO  = 0;
  localparam int ST_RUN = 1;

  typedef enum logic [2:0] {
    OP_SET_PERIOD = 3'd0,
    OP_START      = 3'd1,
    OP_STOP       = 3'd2,
    OP_SNAPSHOT   = 3'd3,
    OP_STATUS     = 3'd4
  } cmd_op_e;

  typedef enum logic [3:0] {
    S_IDLE,
    S_WR_PL,
    S_WR_PH,
    S_WR_CTRL,
    S_SNAP_WR,
    S_RD_LO,
    S_RD_HI,
    S_RD_CAP,
    S_RSP,
    S_IRQ_CLR,
    S_GUARD
  } state_e;

  // Control word: ITO/CONT from the shadow copy plus either START or STOP.
  function automatic logic [15:0] ctl_word(input logic [1:0] sh, input logic start);
    logic [15:0] w;
    w = 16'(sh);
    if (start) w[CTL_START] = 1'b1;
    else       w[CTL_STOP]  = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/high_res_timer_host_if.sv
// Avalon-MM connection between the timer host (master) and the timer s1 port.
interface high_res_timer_host_if;
  logic [2:0]  address;
  logic        chipselect;
  logic        write_n;
  logic [15:0] writedata;
  logic [15:0] readdata;

  modport master (
    output address, chipselect, write_n, writedata,
    input  readdata
  );

  modport slave (
    input  address, chipselect, write_n, writedata,
    output readdata
  );
endinterface

// File: rtl/high_res_timer_host.sv
// Avalon-MM master that turns single-word commands into timer bus sequences
// and autonomously services the timer interrupt (clear TO, tick, count).
module high_res_timer_host
  import timer_regs_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic                 clk,
  input  logic                 reset_n,
  input  logic                 cmd_valid,
  output logic                 cmd_ready,
  input  logic [2:0]           cmd_op,
  input  logic [31:0]          cmd_data,
  output logic                 rsp_valid,
  output logic [31:0]          rsp_data,
  output logic                 rsp_err,
  high_res_timer_host_if.master av,
  input  logic                 irq,
  output logic                 tick,
  output logic [CNT_W-1:0]     tick_count
);

  state_e      state, state_nxt;

  logic [2:0]  addr_q, addr_nxt;
  logic        cs_q, cs_nxt;
  logic        wn_q, wn_nxt;
  logic [15:0] wd_q, wd_nxt;
  logic        rsp_valid_q, rsp_valid_nxt;
  logic [31:0] rsp_data_q, rsp_data_nxt;
  logic        rsp_err_q, rsp_err_nxt;
  logic        tick_q, tick_nxt;
  logic [CNT_W-1:0] tick_count_q;
  logic        cnt_inc;
  logic [1:0]  ctl_sh, ctl_nxt;

  // Sequence working data: latched opcode, pending period high half, snapshot low half
  logic [2:0]  op_q, op_nxt;
  logic [15:0] hi_q, hi_nxt;
  logic [15:0] lo_q, lo_nxt;

  // Only acceptance is combinational; an interrupt in IDLE blocks new commands
  assign cmd_ready = (state == S_IDLE) && !irq;

  assign av.address    = addr_q;
  assign av.chipselect = cs_q;
  assign av.write_n    = wn_q;
  assign av.writedata  = wd_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_err       = rsp_err_q;
  assign tick          = tick_q;
  assign tick_count    = tick_count_q;

  // State register
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) state <= S_IDLE;
    else          state <= state_nxt;
  end

  // Next state plus the next values of every registered output
  always_comb begin
    state_nxt     = state;
    addr_nxt      = ADDR_STATUS;
    cs_nxt        = 1'b0;
    wn_nxt        = 1'b1;
    wd_nxt        = 16'd0;
    rsp_valid_nxt = 1'b0;
    rsp_data_nxt  = 32'd0;
    rsp_err_nxt   = 1'b0;
    tick_nxt      = 1'b0;
    cnt_inc       = 1'b0;
    ctl_nxt       = ctl_sh;
    op_nxt        = op_q;
    hi_nxt        = hi_q;
    lo_nxt        = lo_q;

    case (state)
      S_IDLE: begin
        if (irq) begin
          state_nxt = S_IRQ_CLR;
          addr_nxt  = ADDR_STATUS;
          cs_nxt    = 1'b1;
          wn_nxt    = 1'b0;
        end else if (cmd_valid) begin
          op_nxt = cmd_op;
          case (cmd_op)
            OP_SET_PERIOD: begin
              state_nxt = S_WR_PL;
              addr_nxt  = ADDR_PERIOD_L;
              cs_nxt    = 1'b1;
              wn_nxt    = 1'b0;
              wd_nxt    = cmd_data[15:0];
              hi_nxt    = cmd_data[31:16];
            end
            OP_START, OP_STOP: begin
              ctl_nxt   = cmd_data[1:0];
              state_nxt = S_WR_CTRL;
              addr_nxt  = ADDR_CONTROL;
              cs_nxt    = 1'b1;
              wn_nxt    = 1'b0;
              wd_nxt    = ctl_word(ctl_nxt, cmd_op == OP_START);
            end
            OP_SNAPSHOT: begin
              state_nxt = S_SNAP_WR;
              addr_nxt  = ADDR_SNAP_L;
              cs_nxt    = 1'b1;
              wn_nxt    = 1'b0;
            end
            OP_STATUS: begin
              state_nxt = S_RD_LO;
              addr_nxt  = ADDR_STATUS;
            end
            default: begin
              state_nxt     = S_RSP;
              rsp_valid_nxt = 1'b1;
              rsp_err_nxt   = 1'b1;
            end
          endcase
        end
      end
      S_WR_PL: begin
        state_nxt = S_WR_PH;
        addr_nxt  = ADDR_PERIOD_H;
        cs_nxt    = 1'b1;
        wn_nxt    = 1'b0;
        wd_nxt    = hi_q;
      end
      S_WR_PH, S_WR_CTRL: begin
        state_nxt     = S_RSP;
        rsp_valid_nxt = 1'b1;
      end
      S_SNAP_WR: begin
        state_nxt = S_RD_LO;
        addr_nxt  = ADDR_SNAP_L;
      end
      S_RD_LO: begin
        if (op_q == OP_SNAPSHOT) begin
          state_nxt = S_RD_HI;
          addr_nxt  = ADDR_SNAP_H;
        end else begin
          state_nxt = S_RD_CAP;
        end
      end
      S_RD_HI: begin
        state_nxt = S_RD_CAP;
        lo_nxt    = av.readdata;
      end
      S_RD_CAP: begin
        state_nxt     = S_RSP;
        rsp_valid_nxt = 1'b1;
        if (op_q == OP_SNAPSHOT) rsp_data_nxt = {av.readdata, lo_q};
        else rsp_data_nxt = {30'd0, av.readdata[ST_RUN], av.readdata[ST_TO]};
      end
      S_RSP: state_nxt = S_IDLE;
      S_IRQ_CLR: begin
        state_nxt = S_GUARD;
        tick_nxt  = 1'b1;
        cnt_inc   = 1'b1;
      end
      S_GUARD: state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Registered bus, response and interrupt-service outputs
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      addr_q       <= ADDR_STATUS;
      cs_q         <= 1'b0;
      wn_q         <= 1'b1;
      wd_q         <= 16'd0;
      rsp_valid_q  <= 1'b0;
      rsp_data_q   <= 32'd0;
      rsp_err_q    <= 1'b0;
      tick_q       <= 1'b0;
      tick_count_q <= '0;
      ctl_sh       <= 2'b00;
    end else begin
      addr_q      <= addr_nxt;
      cs_q        <= cs_nxt;
      wn_q        <= wn_nxt;
      wd_q        <= wd_nxt;
      rsp_valid_q <= rsp_valid_nxt;
      rsp_data_q  <= rsp_data_nxt;
      rsp_err_q   <= rsp_err_nxt;
      tick_q      <= tick_nxt;
      ctl_sh      <= ctl_nxt;
      if (cnt_inc) tick_count_q <= tick_count_q + CNT_W'(1);
    end
  end

  // Sequence working data; always rewritten before use, so no reset needed
  always_ff @(posedge clk) begin
    op_q <= op_nxt;
    hi_q <= hi_nxt;
    lo_q <= lo_nxt;
  end

endmodule

// File: tb/tb_high_res_timer_host.sv
// Bench for high_res_timer_host: behavioural timer slave, directed scenarios
// and randomized commands checked against per-opcode bus/response expectations.
module tb_high_res_timer_host;
  import timer_regs_pkg::*;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cmd_valid = 1'b0;
  logic        cmd_ready;
  logic [2:0]  cmd_op = 3'd0;
  logic [31:0] cmd_data = 32'd0;
  logic        rsp_valid;
  logic [31:0] rsp_data;
  logic        rsp_err;
  logic        irq;
  logic        tick;
  logic [31:0] tick_count;

  high_res_timer_host_if av_bus();

  high_res_timer_host #(.CNT_W(32)) dut (
    .clk       (clk),
    .reset_n   (reset_n),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_data  (cmd_data),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .rsp_err   (rsp_err),
    .av        (av_bus),
    .irq       (irq),
    .tick      (tick),
    .tick_count(tick_count)
  );

  always #5 clk = ~clk;

  int n_pass = 0;
  int n_fail = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural interval timer slave
  logic [31:0] m_period, m_cnt, m_snap;
  logic        m_to, m_run, m_ito, m_cont;
  logic [15:0] m_rd;
  assign irq = m_to & m_ito;
  assign av_bus.readdata = m_rd;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      m_period <= 32'd0; m_cnt <= 32'd0; m_snap <= 32'd0; m_rd <= 16'd0;
      m_to <= 1'b0; m_run <= 1'b0; m_ito <= 1'b0; m_cont <= 1'b0;
    end else begin
      case (av_bus.address)
        3'd0:    m_rd <= {14'd0, m_run, m_to};
        3'd1:    m_rd <= {14'd0, m_cont, m_ito};
        3'd2:    m_rd <= m_period[15:0];
        3'd3:    m_rd <= m_period[31:16];
        3'd4:    m_rd <= m_snap[15:0];
        3'd5:    m_rd <= m_snap[31:16];
        default: m_rd <= 16'd0;
      endcase
      if (m_run) begin
        if (m_cnt == 32'd0) begin
          m_cnt <= m_period;
          m_to  <= 1'b1;
          if (!m_cont) m_run <= 1'b0;
        end else begin
          m_cnt <= m_cnt - 32'd1;
        end
      end
      if (av_bus.chipselect && !av_bus.write_n) begin
        case (av_bus.address)
          3'd0: m_to <= 1'b0;
          3'd1: begin
            m_ito  <= av_bus.writedata[0];
            m_cont <= av_bus.writedata[1];
            if (av_bus.writedata[2]) m_run <= 1'b1;
            if (av_bus.writedata[3]) m_run <= 1'b0;
          end
          3'd2: begin
            m_period[15:0] <= av_bus.writedata;
            m_cnt <= {m_period[31:16], av_bus.writedata};
            m_run <= 1'b0;
          end
          3'd3: begin
            m_period[31:16] <= av_bus.writedata;
            m_cnt <= {av_bus.writedata, m_period[15:0]};
            m_run <= 1'b0;
          end
          3'd4, 3'd5: m_snap <= m_cnt;
          default: ;
        endcase
      end
    end
  end

  // Interrupt-service observation: tick cycles and status-clear write cycles
  int tick_cyc_q[$];
  int clr_cyc_q[$];
  always @(negedge clk) begin
    if (tick) tick_cyc_q.push_back(cyc);
    if (av_bus.chipselect && !av_bus.write_n && av_bus.address == 3'd0 &&
        av_bus.writedata == 16'd0) clr_cyc_q.push_back(cyc);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_addr"},   32'(av_bus.address), 32'd0);
    chk({tag, "_cs"},     32'(av_bus.chipselect), 32'd0);
    chk({tag, "_wn"},     32'(av_bus.write_n), 32'd1);
    chk({tag, "_wd"},     32'(av_bus.writedata), 32'd0);
    chk({tag, "_rv"},     32'(rsp_valid), 32'd0);
    chk({tag, "_rd"},     rsp_data, 32'd0);
    chk({tag, "_re"},     32'(rsp_err), 32'd0);
    chk({tag, "_tick"},   32'(tick), 32'd0);
    chk({tag, "_tcnt"},   tick_count, 32'd0);
    chk({tag, "_ready"},  32'(cmd_ready), 32'd1);
  endtask

  // Issue one command (called at a negedge) and check its whole bus sequence.
  // kind: 0 bus idle, 1 read, 2 write with data, 3 write (data unchecked)
  task automatic do_cmd(input logic [2:0] op, input logic [31:0] data, input string tag,
                        output logic [31:0] got, output int t_acc);
    int w;
    int n;
    int kind[6];
    logic [2:0]  adr[6];
    logic [15:0] wdat[6];
    logic [31:0] exp_data;
    logic        exp_err;
    n = 1; exp_data = 32'd0; exp_err = 1'b0; got = 32'd0;
    for (int k = 0; k < 6; k++) begin kind[k] = 0; adr[k] = 3'd0; wdat[k] = 16'd0; end
    case (op)
      3'd0: begin
        n = 3;
        kind[1] = 2; adr[1] = 3'd2; wdat[1] = data[15:0];
        kind[2] = 2; adr[2] = 3'd3; wdat[2] = data[31:16];
      end
      3'd1: begin n = 2; kind[1] = 2; adr[1] = 3'd1; wdat[1] = {12'd0, 2'b01, data[1:0]}; end
      3'd2: begin n = 2; kind[1] = 2; adr[1] = 3'd1; wdat[1] = {12'd0, 2'b10, data[1:0]}; end
      3'd3: begin
        n = 5;
        kind[1] = 3; adr[1] = 3'd4;
        kind[2] = 1; adr[2] = 3'd4;
        kind[3] = 1; adr[3] = 3'd5;
      end
      3'd4: begin n = 3; kind[1] = 1; adr[1] = 3'd0; end
      default: begin n = 1; exp_err = 1'b1; end
    endcase
    cmd_op = op; cmd_data = data; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
    chk({tag, "_accept"}, 32'(cmd_ready), 32'd1);
    t_acc = cyc;
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    for (int k = 1; k <= n; k++) begin
      if (k == 1) begin
        if (op == 3'd3)      exp_data = m_cnt;
        else if (op == 3'd4) exp_data = {30'd0, m_run, m_to};
      end
      if (kind[k] >= 2) begin
        chk($sformatf("%s_t%0d_cs", tag, k), 32'(av_bus.chipselect), 32'd1);
        chk($sformatf("%s_t%0d_wn", tag, k), 32'(av_bus.write_n), 32'd0);
        chk($sformatf("%s_t%0d_addr", tag, k), 32'(av_bus.address), 32'(adr[k]));
        if (kind[k] == 2)
          chk($sformatf("%s_t%0d_wd", tag, k), 32'(av_bus.writedata), 32'(wdat[k]));
      end else begin
        chk($sformatf("%s_t%0d_cs", tag, k), 32'(av_bus.chipselect), 32'd0);
        chk($sformatf("%s_t%0d_wn", tag, k), 32'(av_bus.write_n), 32'd1);
        if (kind[k] == 1)
          chk($sformatf("%s_t%0d_addr", tag, k), 32'(av_bus.address), 32'(adr[k]));
      end
      chk($sformatf("%s_t%0d_rv", tag, k), 32'(rsp_valid), (k == n) ? 32'd1 : 32'd0);
      if (k == n) begin
        chk({tag, "_err"}, 32'(rsp_err), 32'(exp_err));
        chk({tag, "_data"}, rsp_data, exp_data);
        got = rsp_data;
      end else begin
        @(negedge clk);
      end
    end
  endtask

  initial begin
    logic [31:0] got;
    int tacc;
    int w;
    int i_cyc;
    int rv;
    logic found;
    logic [2:0]  rop;
    logic [31:0] rdat;

    // Reset
    repeat (3) @(negedge clk);
    chk_reset("rst");
    reset_n = 1'b1;
    @(negedge clk);

    // Period programming, start, status, snapshot while running, stop
    do_cmd(3'd0, 32'h0001_5F8F, "setper", got, tacc);
    do_cmd(3'd1, 32'd3, "start3", got, tacc);
    do_cmd(3'd4, 32'd0, "status_run", got, tacc);
    chk("status_run_value", got, 32'h2);
    repeat (7) @(negedge clk);
    do_cmd(3'd3, 32'd0, "snap_run", got, tacc);
    do_cmd(3'd2, 32'd0, "stop0", got, tacc);

    // Periodic interrupt servicing: period 9, continuous, ITO
    do_cmd(3'd0, 32'd9, "per9", got, tacc);
    tick_cyc_q.delete();
    clr_cyc_q.delete();
    do_cmd(3'd1, 32'd3, "per9_start", got, tacc);
    w = 0;
    while (tick_cyc_q.size() < 5 && w < 200) begin @(negedge clk); w++; end
    chk("ticks_seen", 32'(tick_cyc_q.size() >= 5), 32'd1);
    chk("tick_count5", tick_count, 32'd5);
    for (int i = 1; i < 5 && i < tick_cyc_q.size(); i++)
      chk($sformatf("tick_gap%0d", i), 32'(tick_cyc_q[i] - tick_cyc_q[i-1]), 32'd10);
    for (int i = 0; i < 5 && i < tick_cyc_q.size(); i++) begin
      found = 1'b0;
      foreach (clr_cyc_q[j]) if (clr_cyc_q[j] == tick_cyc_q[i] - 1) found = 1'b1;
      chk($sformatf("tick_clr%0d", i), 32'(found), 32'd1);
    end
    do_cmd(3'd2, 32'd0, "per9_stop", got, tacc);

    // Interrupt and command in the same IDLE cycle
    do_cmd(3'd0, 32'd9, "irq_per", got, tacc);
    do_cmd(3'd1, 32'd1, "irq_start", got, tacc);
    w = 0;
    while (!irq && w < 100) begin @(negedge clk); w++; end
    chk("irq_seen", 32'(irq), 32'd1);
    i_cyc = cyc;
    cmd_op = 3'd4; cmd_data = 32'd0; cmd_valid = 1'b1;
    chk("irq_i0_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("irq_i1_cs", 32'(av_bus.chipselect), 32'd1);
    chk("irq_i1_wn", 32'(av_bus.write_n), 32'd0);
    chk("irq_i1_addr", 32'(av_bus.address), 32'd0);
    chk("irq_i1_wd", 32'(av_bus.writedata), 32'd0);
    chk("irq_i1_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    chk("irq_i2_tick", 32'(tick), 32'd1);
    chk("irq_i2_cs", 32'(av_bus.chipselect), 32'd0);
    chk("irq_i2_ready", 32'(cmd_ready), 32'd0);
    @(negedge clk);
    do_cmd(3'd4, 32'd0, "irq_status", got, tacc);
    chk("irq_accept_cycle", 32'(tacc), 32'(i_cyc + 3));

    // Illegal opcode
    do_cmd(3'd6, 32'hFFFF_FFFF, "illegal6", got, tacc);
    @(negedge clk);
    chk("illegal6_pulse_end", 32'(rsp_valid), 32'd0);

    // Randomized command stream
    for (int r = 0; r < 30; r++) begin
      rop  = 3'($urandom_range(0, 7));
      rdat = $urandom();
      if (rop == 3'd0) rdat = 32'($urandom_range(3, 40));
      do_cmd(rop, rdat, $sformatf("rnd%0d_op%0d", r, rop), got, tacc);
      repeat ($urandom_range(0, 3)) @(negedge clk);
    end

    // Reset in the middle of a snapshot (during the high-half read)
    do_cmd(3'd0, 32'd50, "pre_rst_per", got, tacc);
    do_cmd(3'd1, 32'd2, "pre_rst_start", got, tacc);
    cmd_op = 3'd3; cmd_data = 32'd0; cmd_valid = 1'b1;
    w = 0;
    while (!cmd_ready && w < 200) begin @(negedge clk); w++; end
    chk("rst_mid_accept", 32'(cmd_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    cmd_valid = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_rdhi_addr", 32'(av_bus.address), 32'd5);
    reset_n = 1'b0;
    #1;
    chk_reset("rst_mid");
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    rv = 0;
    repeat (8) begin
      @(negedge clk);
      if (rsp_valid) rv++;
    end
    chk("rst_mid_no_rsp", 32'(rv), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
